// File: rtl/cpu7_dmem_resp_if.sv
// Pipeline-side data memory request/response bus.
// Master is the pipeline, slave is the response unit.
interface cpu7_dmem_resp_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_recv;
  logic        data_cancel;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        data_exception;
  logic [5:0]  data_excode;
  logic [31:0] data_badvaddr;
  logic        data_req_empty;

  modport master (
    output data_req, data_addr, data_wr, data_wstrb,
    output data_wdata, data_recv, data_cancel,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  data_exception, data_excode, data_badvaddr,
    input  data_req_empty
  );

  modport slave (
    input  data_req, data_addr, data_wr, data_wstrb,
    input  data_wdata, data_recv, data_cancel,
    output data_addr_ok, data_data_ok, data_rdata,
    output data_exception, data_excode, data_badvaddr,
    output data_req_empty
  );
endinterface

// File: rtl/cpu7_dmem_resp.sv
// Data memory response unit: 2-entry in-order queue
// over a synchronous SRAM with alignment checking.
module cpu7_dmem_resp #(
  parameter int RAM_AW = 10,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  cpu7_dmem_resp_if.slave   bus,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]  count;
  logic        head;
  logic        tail;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [1:0]  exc;
  logic [31:0] data [2];
  logic [31:0] badv [2];
  logic        rd_pend;
  logic        rd_idx;

  logic misal;
  logic addr_ok;
  logic push;
  logic mem_acc;
  logic load_acc;
  logic data_ok;
  logic pop;
  logic unused_addr;

  assign unused_addr = ^bus.data_addr[31:RAM_AW+2];

  // Alignment rule per byte-lane pattern.
  always_comb begin
    misal = 1'b1;
    case (bus.data_wstrb)
      4'b1111: misal = |bus.data_addr[1:0];
      4'b0011,
      4'b1100: misal = bus.data_addr[0];
      4'b0001,
      4'b0010,
      4'b0100,
      4'b1000: misal = 1'b0;
      default: misal = 1'b1;
    endcase
  end

  assign addr_ok  = ~reset & (count < FULL) & ~bus.data_cancel;
  assign push     = bus.data_req & addr_ok;
  assign mem_acc  = push & ~misal;
  assign load_acc = mem_acc & ~bus.data_wr;
  assign data_ok  = valid[head] & ready[head];
  assign pop      = data_ok & bus.data_recv & ~bus.data_cancel;

  assign ram_en    = mem_acc;
  assign ram_we    = (mem_acc & bus.data_wr) ? bus.data_wstrb : 4'b0;
  assign ram_addr  = bus.data_addr[RAM_AW+1:2];
  assign ram_wdata = bus.data_wdata;

  assign bus.data_addr_ok   = addr_ok;
  assign bus.data_data_ok   = data_ok;
  assign bus.data_rdata     = data_ok ? data[head] : 32'h0;
  assign bus.data_exception = data_ok & exc[head];
  assign bus.data_excode    = (data_ok & exc[head]) ? 6'h09 : 6'h00;
  assign bus.data_badvaddr  = (data_ok & exc[head]) ? badv[head] : 32'h0;
  assign bus.data_req_empty = (count == 2'd0);

  // Queue control: pointers, count, valid/ready and load-in-flight tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 2'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      valid   <= 2'b00;
      ready   <= 2'b00;
      exc     <= 2'b00;
      rd_pend <= 1'b0;
    end else if (bus.data_cancel) begin
      count   <= 2'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      valid   <= 2'b00;
      ready   <= 2'b00;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= load_acc;
      if (rd_pend) ready[rd_idx] <= 1'b1;
      if (push) begin
        valid[tail] <= 1'b1;
        ready[tail] <= ~load_acc;
        exc[tail]   <= misal;
        tail        <= ~tail;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= ~head;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Entry payload: load data captured the cycle after the SRAM read.
  always_ff @(posedge clk) begin
    if (rd_pend) data[rd_idx] <= ram_rdata;
    if (push) begin
      data[tail] <= 32'h0;
      badv[tail] <= misal ? bus.data_addr : 32'h0;
    end
    if (load_acc) rd_idx <= tail;
  end

endmodule

// File: tb/tb_cpu7_dmem_resp.sv
// Self-checking bench for cpu7_dmem_resp: queue-level response
// model checked every cycle plus directed literal expectations.
module tb_cpu7_dmem_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int total = 0;
  int npass = 0;
  int cyc = 0;

  cpu7_dmem_resp_if bus();

  cpu7_dmem_resp #(.RAM_AW(10), .DEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [1024];
  logic [31:0] mdl [1024];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'h0;
      mdl[i] = 32'h0;
    end
  end

  // Behavioural SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) sram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= sram[ram_addr];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit is_fault(logic [3:0] s, logic [31:0] a);
    if (s == 4'hF) return a[1:0] != 2'b00;
    if (s == 4'h3 || s == 4'hC) return a[0];
    if ($countones(s) == 1) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    int          rdy;
    logic [31:0] rdata;
    bit          exc;
    logic [31:0] badv;
  } ent_t;

  ent_t q[$];

  // Model: compare every cycle, then advance the response queue.
  always @(negedge clk) begin
    bit acc, flt, dok;
    ent_t e;
    logic [31:0] w;
    logic [9:0] ix;
    cyc++;
    if (reset) begin
      q.delete();
      chk("rst_addr_ok", bus.data_addr_ok, 0);
      chk("rst_data_ok", bus.data_data_ok, 0);
      chk("rst_rdata", bus.data_rdata, 0);
      chk("rst_exc", bus.data_exception, 0);
      chk("rst_excode", bus.data_excode, 0);
      chk("rst_badv", bus.data_badvaddr, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_empty", bus.data_req_empty, 1);
    end else begin
      acc = bus.data_req && q.size() < 2 && !bus.data_cancel;
      flt = is_fault(bus.data_wstrb, bus.data_addr);
      dok = q.size() > 0 && cyc >= q[0].rdy;
      ix = bus.data_addr[11:2];
      chk("m_addr_ok", bus.data_addr_ok,
          q.size() < 2 && !bus.data_cancel);
      chk("m_empty", bus.data_req_empty, q.size() == 0);
      chk("m_data_ok", bus.data_data_ok, dok);
      if (dok) begin
        chk("m_rdata", bus.data_rdata, q[0].rdata);
        chk("m_exc", bus.data_exception, q[0].exc);
        chk("m_excode", bus.data_excode, q[0].exc ? 6'h09 : 6'h00);
        chk("m_badv", bus.data_badvaddr, q[0].badv);
      end
      chk("m_ram_en", ram_en, acc && !flt);
      chk("m_ram_we", ram_we,
          (acc && !flt && bus.data_wr) ? bus.data_wstrb : 4'h0);
      if (acc && !flt) begin
        chk("m_ram_addr", ram_addr, ix);
        chk("m_ram_wdata", ram_wdata, bus.data_wdata);
      end
      if (bus.data_cancel) begin
        q.delete();
      end else begin
        if (dok && bus.data_recv) void'(q.pop_front());
        if (acc) begin
          e.exc = flt;
          e.badv = flt ? bus.data_addr : 32'h0;
          e.rdata = 32'h0;
          e.rdy = cyc + 1;
          if (!flt && bus.data_wr) begin
            w = mdl[ix];
            for (int i = 0; i < 4; i++)
              if (bus.data_wstrb[i]) w[8*i +: 8] = bus.data_wdata[8*i +: 8];
            mdl[ix] = w;
          end else if (!flt) begin
            e.rdata = mdl[ix];
            e.rdy = cyc + 2;
          end
          q.push_back(e);
        end
      end
    end
  end

  task automatic drive(bit rq, logic [31:0] a, bit w, logic [3:0] s,
                       logic [31:0] d, bit rv, bit cn);
    @(posedge clk);
    #1;
    bus.data_req = rq;
    bus.data_addr = a;
    bus.data_wr = w;
    bus.data_wstrb = s;
    bus.data_wdata = d;
    bus.data_recv = rv;
    bus.data_cancel = cn;
  endtask

  task automatic idle(bit rv);
    drive(0, 32'h0, 0, 4'h0, 32'h0, rv, 0);
  endtask

  initial begin
    bus.data_req = 0;
    bus.data_addr = 0;
    bus.data_wr = 0;
    bus.data_wstrb = 0;
    bus.data_wdata = 0;
    bus.data_recv = 0;
    bus.data_cancel = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold_empty", bus.data_req_empty, 1);
    chk("rst_hold_aok", bus.data_addr_ok, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rel_aok", bus.data_addr_ok, 1);

    // store then word load
    drive(1, 32'h100, 1, 4'hF, 32'h12345678, 1, 0);
    @(negedge clk);
    chk("t44_pre", bus.data_data_ok, 0);
    drive(1, 32'h100, 0, 4'hF, 32'h0, 1, 0);
    @(negedge clk);
    chk("t44_st_ok", bus.data_data_ok, 1);
    idle(1);
    @(negedge clk);
    chk("t44_ld_wait", bus.data_data_ok, 0);
    idle(1);
    @(negedge clk);
    chk("t44_ld_ok", bus.data_data_ok, 1);
    chk("t44_rdata", bus.data_rdata, 32'h12345678);

    // byte store merge
    drive(1, 32'h102, 1, 4'b0100, 32'h00AB0000, 1, 0);
    drive(1, 32'h100, 0, 4'hF, 32'h0, 1, 0);
    idle(1);
    idle(1);
    @(negedge clk);
    chk("t45_ok", bus.data_data_ok, 1);
    chk("t45_rdata", bus.data_rdata, 32'h12AB5678);

    // misaligned word load
    drive(1, 32'h101, 0, 4'hF, 32'h0, 1, 0);
    @(negedge clk);
    chk("t46_ram_en", ram_en, 0);
    idle(1);
    @(negedge clk);
    chk("t46_ok", bus.data_data_ok, 1);
    chk("t46_exc", bus.data_exception, 1);
    chk("t46_excode", bus.data_excode, 6'h09);
    chk("t46_badv", bus.data_badvaddr, 32'h101);
    chk("t46_rdata", bus.data_rdata, 0);

    // other alignment patterns
    drive(1, 32'h101, 0, 4'h3, 32'h0, 1, 0);
    drive(1, 32'h102, 1, 4'hC, 32'hBEEF0000, 1, 0);
    drive(1, 32'h100, 1, 4'h5, 32'hFFFFFFFF, 1, 0);
    drive(1, 32'h103, 0, 4'h8, 32'h0, 1, 0);
    drive(1, 32'h104, 1, 4'hF, 32'h11111111, 1, 0);
    drive(1, 32'h108, 1, 4'hF, 32'h22222222, 1, 0);
    idle(1);
    idle(1);

    // backpressure with three back-to-back loads
    drive(1, 32'h100, 0, 4'hF, 32'h0, 0, 0);
    drive(1, 32'h104, 0, 4'hF, 32'h0, 0, 0);
    drive(1, 32'h108, 0, 4'hF, 32'h0, 0, 0);
    @(negedge clk);
    chk("t47_full", bus.data_addr_ok, 0);
    idle(0);
    idle(0);
    idle(0);
    @(negedge clk);
    chk("t47_hold_ok", bus.data_data_ok, 1);
    chk("t47_hold_rd", bus.data_rdata, 32'hBEEF5678);
    idle(1);
    @(negedge clk);
    chk("t47_r0", bus.data_rdata, 32'hBEEF5678);
    idle(1);
    @(negedge clk);
    chk("t47_r1", bus.data_rdata, 32'h11111111);
    idle(1);
    @(negedge clk);
    chk("t47_empty", bus.data_req_empty, 1);
    chk("t47_nodok", bus.data_data_ok, 0);

    // cancel does not undo a written store
    drive(1, 32'h10C, 1, 4'hF, 32'hCAFEF00D, 0, 0);
    drive(0, 32'h0, 0, 4'h0, 32'h0, 0, 1);
    drive(1, 32'h10C, 0, 4'hF, 32'h0, 1, 0);
    idle(1);
    idle(1);
    @(negedge clk);
    chk("t36_ok", bus.data_data_ok, 1);
    chk("t36_rdata", bus.data_rdata, 32'hCAFEF00D);

    // cancel with two loads outstanding
    drive(1, 32'h100, 0, 4'hF, 32'h0, 0, 0);
    drive(1, 32'h104, 0, 4'hF, 32'h0, 0, 0);
    drive(1, 32'h108, 0, 4'hF, 32'h0, 0, 1);
    @(negedge clk);
    chk("t48_aok", bus.data_addr_ok, 0);
    chk("t48_ram_en", ram_en, 0);
    idle(1);
    @(negedge clk);
    chk("t48_empty", bus.data_req_empty, 1);
    chk("t48_nodok0", bus.data_data_ok, 0);
    idle(1);
    @(negedge clk);
    chk("t48_nodok1", bus.data_data_ok, 0);
    idle(1);

    // reset with a load in flight
    drive(1, 32'h104, 0, 4'hF, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    bus.data_req = 0;
    reset = 1;
    @(negedge clk);
    chk("t49_dok", bus.data_data_ok, 0);
    chk("t49_aok", bus.data_addr_ok, 0);
    chk("t49_ram_en", ram_en, 0);
    chk("t49_empty", bus.data_req_empty, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("t49_rel_aok", bus.data_addr_ok, 1);
    chk("t49_rel_dok", bus.data_data_ok, 0);
    idle(1);
    idle(1);
    idle(1);
    @(negedge clk);
    chk("t49_stale", bus.data_data_ok, 0);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
